data_mem_bridge: RTL and testbench

//  Sits between the openmips core data port (ram_*) and the synchronous data BRAM.

---
 rtl/data_mem_bridge.sv | 127 ++++++++++++
 tb/tb_data_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// data_mem_bridge : openmips data port to synchronous BRAM bridge + GPIO MMIO
//   Optional access counter at MMIO offset 0x8 enabled by BRIDGE_ACC_CNT_EN.
// Revision: 1.0
// ============================================================================
module data_mem_bridge #(
  parameter int          BRAM_AW   = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ram_ce_i,
  input  logic               ram_we_i,
  input  logic [31:0]        ram_addr_i,
  input  logic [3:0]         ram_sel_i,
  input  logic [31:0]        ram_data_i,
  output logic [31:0]        ram_data_o,
  output logic               stallreq_o,
  output logic               bram_en_o,
  output logic [3:0]         bram_we_o,
  output logic [BRAM_AW-1:0] bram_addr_o,
  output logic [31:0]        bram_din_o,
  input  logic [31:0]        bram_dout_i,
  input  logic [31:0]        gpio_i,
  output logic [31:0]        gpio_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    RWAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        mmio;
  logic [13:0] reg_word;
  logic [31:0] mmio_rdata;
  logic        gpio_wr;
  logic        unused;

  assign mmio        = (ram_addr_i[31:16] == MMIO_BASE[31:16]);
  assign reg_word    = ram_addr_i[15:2];
  assign bram_addr_o = ram_addr_i[BRAM_AW+1:2];
  assign bram_din_o  = ram_data_i;
  assign gpio_wr     = (state == IDLE) && ram_ce_i && ram_we_i && mmio && (reg_word == 14'h0);
  assign unused      = &{1'b0, ram_addr_i[1:0]};

`ifdef BRIDGE_ACC_CNT_EN
  logic [31:0] acc_cnt;
  logic        access_done;

  // A load completes in RWAIT; stores and MMIO accesses complete in IDLE.
  assign access_done = ram_ce_i &&
                       ((state == RWAIT) || (ram_we_i || mmio));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= 32'd0;
    end else if (access_done) begin
      acc_cnt <= acc_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    mmio_rdata = 32'd0;
    case (reg_word)
      14'h0:   mmio_rdata = gpio_o;
      14'h1:   mmio_rdata = gpio_i;
`ifdef BRIDGE_ACC_CNT_EN
      14'h2:   mmio_rdata = acc_cnt;
`endif
      default: mmio_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_o <= 32'd0;
    end else if (gpio_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel_i[i]) gpio_o[8*i +: 8] <= ram_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    ram_data_o = 32'd0;
    stallreq_o = 1'b0;
    bram_en_o  = 1'b0;
    bram_we_o  = 4'd0;
    case (state)
      IDLE: begin
        if (ram_ce_i) begin
          if (mmio) begin
            if (!ram_we_i) ram_data_o = mmio_rdata;
          end else if (ram_we_i) begin
            bram_en_o = 1'b1;
            bram_we_o = ram_sel_i;
          end else begin
            bram_en_o  = 1'b1;
            stallreq_o = 1'b1;
            state_next = RWAIT;
          end
        end
      end
      RWAIT: begin
        // If the core withdrew the request the BRAM data is simply dropped.
        if (ram_ce_i) ram_data_o = bram_dout_i;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// tb_data_mem_bridge : directed bench with a transaction-level reference model
// Revision: 1.0
// ============================================================================
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;

  int checks = 0;
  int errors = 0;

  data_mem_bridge #(.BRAM_AW(10), .MMIO_BASE(32'h1000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_ce_i    (ce),
    .ram_we_i    (we),
    .ram_addr_i  (addr),
    .ram_sel_i   (sel),
    .ram_data_i  (wdata),
    .ram_data_o  (rdata),
    .stallreq_o  (stall),
    .bram_en_o   (bram_en),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_din_o  (bram_din),
    .bram_dout_i (bram_dout),
    .gpio_i      (gpio_in),
    .gpio_o      (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous BRAM environment: read-first, one cycle latency.
  logic [31:0] bram [0:1023];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int i = 0; i < 4; i++)
        if (bram_we[i]) bram[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
      bram_dout <= bram[bram_addr];
    end
  end

  // Reference model: memory contents, GPIO register, access count and
  // whether a BRAM load is waiting for its data.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] m_gpio;
  logic [31:0] m_cnt;
  logic        m_wait;
  logic        preload_ev = 1'b0;

  wire         m_mmio  = (addr[31:16] == 16'h1000);
  wire  [9:0]  m_word  = addr[11:2];
  wire         m_store = !m_wait && ce && we && !m_mmio;
  wire         m_load  = !m_wait && ce && !we && !m_mmio;
  wire         m_done  = ce && (m_wait || we || m_mmio);

  always @(posedge clk) begin
    if (m_store)
      for (int i = 0; i < 4; i++)
        if (sel[i]) ref_mem[m_word][8*i +: 8] <= wdata[8*i +: 8];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0;
      m_gpio <= 32'd0;
    end else begin
      m_wait <= m_load;
      if (!m_wait && ce && we && m_mmio && addr[15:2] == 14'd0)
        for (int i = 0; i < 4; i++)
          if (sel[i]) m_gpio[8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always @(posedge clk or posedge rst or posedge preload_ev) begin
    if (rst)             m_cnt <= 32'd0;
    else if (preload_ev) m_cnt <= 32'hFFFF_FFFF;
    else if (m_done)     m_cnt <= m_cnt + 32'd1;
  end

  function automatic logic [31:0] mmio_read(input logic [31:0] a);
    case (a[15:2])
      14'd0: return m_gpio;
      14'd1: return gpio_in;
`ifdef BRIDGE_ACC_CNT_EN
      14'd2: return m_cnt;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e_data;
    logic        e_stall, e_en;
    logic [3:0]  e_we;
    e_data = 32'd0; e_stall = 1'b0; e_en = 1'b0; e_we = 4'd0;
    if (m_wait) begin
      if (ce) e_data = ref_mem[m_word];
    end else if (ce) begin
      if (m_mmio) begin
        if (!we) e_data = mmio_read(addr);
      end else begin
        e_en = 1'b1;
        if (we) e_we = sel;
        else    e_stall = 1'b1;
      end
    end
    chk("cyc_stall", {31'd0, stall}, {31'd0, e_stall});
    chk("cyc_bram_en", {31'd0, bram_en}, {31'd0, e_en});
    chk("cyc_bram_we", {28'd0, bram_we}, {28'd0, e_we});
    chk("cyc_rdata", rdata, e_data);
    chk("cyc_gpio", gpio_out, m_gpio);
    if (e_en) begin
      chk("cyc_bram_addr", {22'd0, bram_addr}, {22'd0, m_word});
      chk("cyc_bram_din", bram_din, wdata);
    end
  end

  // One core access starting just after a rising edge; ends just after
  // the edge on which it completes, leaving ce asserted.
  logic [7:0]  stall_hist;
  logic [3:0]  last_we;
  logic [9:0]  last_addr;

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp, input int exp_stalls);
    int  nstall = 0;
    bit  done = 0;
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    for (int c = 0; c < 4 && !done; c++) begin
      @(negedge clk);
      stall_hist = {stall_hist[6:0], stall};
      if (stall) begin
        nstall++;
        @(posedge clk); #1;
      end else begin
        if (!w) chk("xfer_rdata", rdata, exp);
        last_we = bram_we; last_addr = bram_addr;
        done = 1;
      end
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    chk("xfer_stalls", nstall, exp_stalls);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0;
    wdata = 32'd0; gpio_in = 32'd0; stall_hist = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a wait state: straight back to IDLE.
    ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
    @(negedge clk);
    chk("rwait_entry_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_rwait_stall", {31'd0, stall}, 32'd1);
    chk("rst_rwait_en", {31'd0, bram_en}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0;
    @(posedge clk); #1;

    // Word store then load.
    xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0, 0);
    chk("store_we", {28'd0, last_we}, 32'hF);
    chk("store_addr", {22'd0, last_addr}, 32'd4);
    xfer(1'b0, 32'h10, 4'hF, 32'd0, 32'hDEAD_BEEF, 1);

    // Byte-lane store.
    xfer(1'b1, 32'h13, 4'b1000, 32'hAA00_0000, 32'd0, 0);
    chk("byte_we", {28'd0, last_we}, 32'h8);
    xfer(1'b0, 32'h10, 4'hF, 32'd0, 32'hAAAD_BEEF, 1);

    // MMIO.
    xfer(1'b1, 32'h1000_0000, 4'b0011, 32'h1234_5678, 32'd0, 0);
    chk("gpio_out", gpio_out, 32'h0000_5678);
    gpio_in = 32'hCAFE_0001;
    xfer(1'b0, 32'h1000_0004, 4'hF, 32'd0, 32'hCAFE_0001, 0);
    xfer(1'b0, 32'h1000_000C, 4'hF, 32'd0, 32'd0, 0);
    xfer(1'b0, 32'h1000_0000, 4'hF, 32'd0, 32'h0000_5678, 0);
    xfer(1'b1, 32'h1000_0004, 4'hF, 32'hFFFF_FFFF, 32'd0, 0);
    chk("gpio_in_ro", gpio_out, 32'h0000_5678);

    // Back-to-back loads.
    xfer(1'b1, 32'h20, 4'hF, 32'h1111_1111, 32'd0, 0);
    xfer(1'b1, 32'h24, 4'hF, 32'h2222_2222, 32'd0, 0);
    stall_hist = 8'd0;
    xfer(1'b0, 32'h20, 4'hF, 32'd0, 32'h1111_1111, 1);
    xfer(1'b0, 32'h24, 4'hF, 32'd0, 32'h2222_2222, 1);
    chk("b2b_stall_pattern", {28'd0, stall_hist[3:0]}, 32'b1010);

    // Request withdrawn during the wait state.
    ce = 1'b1; we = 1'b0; addr = 32'h20; sel = 4'hF;
    @(negedge clk);
    chk("drop_stall_hi", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    ce = 1'b0;
    @(negedge clk);
    chk("drop_stall_lo", {31'd0, stall}, 32'd0);
    chk("drop_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    xfer(1'b0, 32'h24, 4'hF, 32'd0, 32'h2222_2222, 1);

`ifdef BRIDGE_ACC_CNT_EN
    ce = 1'b0; rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 32'h30, 4'hF, 32'h5A5A_5A5A, 32'd0, 0);
    xfer(1'b0, 32'h30, 4'hF, 32'd0, 32'h5A5A_5A5A, 1);
    xfer(1'b1, 32'h1000_0000, 4'hF, 32'h0000_0001, 32'd0, 0);
    xfer(1'b0, 32'h1000_0008, 4'hF, 32'd0, 32'd3, 0);
    ce = 1'b0;
    force dut.acc_cnt = 32'hFFFF_FFFF;
    preload_ev = 1'b1;
    #1;
    release dut.acc_cnt;
    preload_ev = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h1000_0008, 4'hF, 32'd0, 32'hFFFF_FFFF, 0);
    xfer(1'b0, 32'h1000_0008, 4'hF, 32'd0, 32'd0, 0);
`else
    xfer(1'b0, 32'h1000_0008, 4'hF, 32'd0, 32'd0, 0);
`endif

    ce = 1'b0;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
